// File: rtl/popcount_sequencer.sv
// popcount_sequencer
// Feeds a W-bit operand to a shared external 17-input popcount tree one
// 17-bit chunk per cycle, sums the per-chunk counts and hands the total
// to the consumer over a valid/ready handshake.
module popcount_sequencer #(
  parameter  int W     = 64,
  localparam int CHUNK = 17,
  localparam int NCH   = (W + CHUNK - 1) / CHUNK,
  localparam int CW    = $clog2(W + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [W-1:0]     i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [CW-1:0]    o_out_count,
  output logic             o_busy,
  output logic [CHUNK-1:0] o_cmp_y,
  input  logic [4:0]       i_cmp_cnt
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW = NCH * CHUNK;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_acc;
  logic [CW-1:0]   r_count;
  logic [DW-1:0]   r_data;
  logic            r_started;
  logic            w_accept;
  logic            w_lastChunk;
  logic [CW-1:0]   w_sum;
  logic [CHUNK-1:0] w_chunk;

  // in_ready stays low through reset and rises on the first edge after release
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_lastChunk = (r_idx == IW'(NCH - 1));
  assign w_sum       = r_acc + CW'(i_cmp_cnt);
  assign w_chunk     = r_data[r_idx*CHUNK +: CHUNK];
  assign o_out_count = r_count;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; clear overrides every other transition
  always_comb begin
    w_next = r_state;
    if (i_clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_next = S_RUN;
        S_RUN:   if (w_lastChunk) w_next = S_DONE;
        S_DONE:  if (i_out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; tree inputs are held at zero outside RUN
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    o_cmp_y     = '0;
    case (r_state)
      S_IDLE: o_in_ready = r_started;
      S_RUN: begin
        o_busy  = 1'b1;
        o_cmp_y = w_chunk;
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
      end
      default: o_in_ready = 1'b0;
    endcase
  end

  // Datapath: operand capture, chunk index, running sum and held result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_started <= 1'b0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_data    <= '0;
    end else begin
      r_started <= 1'b1;
      if (i_clear) begin
        r_idx <= '0;
        r_acc <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_data <= DW'(i_in_data);
              r_acc  <= '0;
              r_idx  <= '0;
            end
          end
          S_RUN: begin
            r_acc <= w_sum;
            if (w_lastChunk) begin
              r_idx   <= '0;
              r_count <= w_sum;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
          default: begin
            r_idx <= r_idx;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Testbench for popcount_sequencer: a W=64 instance exercised with directed
// and random jobs, plus a W=17 instance for the single-chunk case. The
// compressor tree is modelled by $countones on the driven chunk.
module tb_popcount_sequencer;

  localparam int W     = 64;
  localparam int NCH   = 4;
  localparam int CHUNK = 17;

  logic        clk;
  logic        rstN;
  logic        clear;
  logic        inValid;
  logic        inReady;
  logic [63:0] inData;
  logic        outValid;
  logic        outReady;
  logic [6:0]  outCount;
  logic        busy;
  logic [16:0] cmpY;
  logic [4:0]  cmpCnt;

  logic        sClear;
  logic        sInValid;
  logic        sInReady;
  logic [16:0] sInData;
  logic        sOutValid;
  logic        sOutReady;
  logic [4:0]  sOutCount;
  logic        sBusy;
  logic [16:0] sCmpY;
  logic [4:0]  sCmpCnt;

  int nCompared;
  int nMismatched;
  int lastCount;

  // Behavioural compressor trees
  assign cmpCnt  = 5'($countones(cmpY));
  assign sCmpCnt = 5'($countones(sCmpY));

  popcount_sequencer #(.W(64)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_clear(clear),
    .i_in_valid(inValid), .o_in_ready(inReady), .i_in_data(inData),
    .o_out_valid(outValid), .i_out_ready(outReady), .o_out_count(outCount),
    .o_busy(busy), .o_cmp_y(cmpY), .i_cmp_cnt(cmpCnt)
  );

  popcount_sequencer #(.W(17)) dut17 (
    .i_clk(clk), .i_rst_n(rstN), .i_clear(sClear),
    .i_in_valid(sInValid), .o_in_ready(sInReady), .i_in_data(sInData),
    .o_out_valid(sOutValid), .i_out_ready(sOutReady), .o_out_count(sOutCount),
    .o_busy(sBusy), .o_cmp_y(sCmpY), .i_cmp_cnt(sCmpCnt)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full job on the W=64 instance, starting and ending at a negedge in IDLE
  task automatic applyStimulus(input logic [63:0] data, input int hold);
    int expCount;
    expCount = $countones(data);
    checkOutput("idle_in_ready", 64'(inReady), 64'd1);
    inValid = 1'b1;
    inData  = data;
    @(negedge clk);
    inValid = 1'b0;
    inData  = {$urandom, $urandom};
    for (int k = 0; k < NCH; k++) begin
      checkOutput("run_cmp_y", 64'(cmpY), 64'(17'(data >> (CHUNK * k))));
      checkOutput("run_busy", 64'(busy), 64'd1);
      checkOutput("run_out_valid", 64'(outValid), 64'd0);
      checkOutput("run_in_ready", 64'(inReady), 64'd0);
      @(negedge clk);
    end
    checkOutput("done_out_valid", 64'(outValid), 64'd1);
    checkOutput("done_count", 64'(outCount), 64'(expCount));
    checkOutput("done_in_ready", 64'(inReady), 64'd0);
    checkOutput("done_cmp_y", 64'(cmpY), 64'd0);
    for (int h = 0; h < hold; h++) begin
      outReady = 1'b0;
      @(negedge clk);
      checkOutput("bp_out_valid", 64'(outValid), 64'd1);
      checkOutput("bp_count", 64'(outCount), 64'(expCount));
      checkOutput("bp_in_ready", 64'(inReady), 64'd0);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("post_out_valid", 64'(outValid), 64'd0);
    checkOutput("post_in_ready", 64'(inReady), 64'd1);
    checkOutput("post_busy", 64'(busy), 64'd0);
    checkOutput("post_count_hold", 64'(outCount), 64'(expCount));
    lastCount = expCount;
  endtask

  // Full job on the W=17 instance
  task automatic runSmallJob(input logic [16:0] data);
    checkOutput("s_in_ready", 64'(sInReady), 64'd1);
    sInValid = 1'b1;
    sInData  = data;
    @(negedge clk);
    sInValid = 1'b0;
    checkOutput("s_cmp_y", 64'(sCmpY), 64'(data));
    checkOutput("s_run_valid", 64'(sOutValid), 64'd0);
    @(negedge clk);
    checkOutput("s_done_valid", 64'(sOutValid), 64'd1);
    checkOutput("s_done_count", 64'(sOutCount), 64'($countones(data)));
    sOutReady = 1'b1;
    @(negedge clk);
    sOutReady = 1'b0;
    checkOutput("s_post_valid", 64'(sOutValid), 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    nCompared   = 0;
    nMismatched = 0;
    lastCount   = 0;
    rstN = 1'b0; clear = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
    sClear = 1'b0; sInValid = 1'b0; sInData = '0; sOutReady = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 64'(inReady), 64'd0);
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_count", 64'(outCount), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_cmp_y", 64'(cmpY), 64'd0);
    rstN = 1'b1;
    #1;
    checkOutput("release_in_ready_low", 64'(inReady), 64'd0);
    @(negedge clk);
    checkOutput("release_in_ready_high", 64'(inReady), 64'd1);

    // All ones, zero, two sparse bits
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 0);
    applyStimulus(64'h0, 0);
    applyStimulus(64'h8000_0000_0000_0001, 0);

    // Backpressure for five cycles
    applyStimulus(64'h0123_4567_89AB_CDEF, 5);

    // Back-to-back with in_valid held high
    inValid = 1'b1; inData = 64'hFF; outReady = 1'b1;
    @(negedge clk);
    inData = 64'hF0F0;
    checkOutput("b2b_in_ready_run", 64'(inReady), 64'd0);
    repeat (NCH) @(negedge clk);
    checkOutput("b2b_first_valid", 64'(outValid), 64'd1);
    checkOutput("b2b_first_count", 64'(outCount), 64'd8);
    @(negedge clk);
    checkOutput("b2b_gap_in_ready", 64'(inReady), 64'd1);
    checkOutput("b2b_gap_valid", 64'(outValid), 64'd0);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("b2b_second_busy", 64'(busy), 64'd1);
    checkOutput("b2b_second_cmp_y", 64'(cmpY), 64'hF0F0);
    repeat (NCH) @(negedge clk);
    checkOutput("b2b_second_valid", 64'(outValid), 64'd1);
    checkOutput("b2b_second_count", 64'(outCount), 64'd8);
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("b2b_end_in_ready", 64'(inReady), 64'd1);

    // Asynchronous reset while RUN is on chunk 2
    d = 64'hFFFF_0000_FFFF_0000;
    inValid = 1'b1; inData = d;
    @(negedge clk);
    inValid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("arst_cmp_y_idx2", 64'(cmpY), 64'(17'(d >> (2 * CHUNK))));
    #2 rstN = 1'b0;
    #1;
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_in_ready", 64'(inReady), 64'd0);
    checkOutput("arst_out_valid", 64'(outValid), 64'd0);
    checkOutput("arst_count", 64'(outCount), 64'd0);
    checkOutput("arst_cmp_y", 64'(cmpY), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("arst_recover_ready", 64'(inReady), 64'd1);
    lastCount = 0;

    // Clear mid-RUN: job discarded, out_count keeps old value
    inValid = 1'b1; inData = 64'hFFFF;
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clr_run_busy", 64'(busy), 64'd0);
    checkOutput("clr_run_ready", 64'(inReady), 64'd1);
    checkOutput("clr_run_cmp_y", 64'(cmpY), 64'd0);
    repeat (NCH + 1) @(negedge clk);
    checkOutput("clr_run_no_valid", 64'(outValid), 64'd0);
    checkOutput("clr_run_count_hold", 64'(outCount), 64'(lastCount));
    applyStimulus(64'h0000_00F0_0000_0F0F, 0);

    // Clear blocks an accept in IDLE
    inValid = 1'b1; inData = 64'h1; clear = 1'b1;
    @(negedge clk);
    inValid = 1'b0; clear = 1'b0;
    checkOutput("clr_accept_busy", 64'(busy), 64'd0);
    checkOutput("clr_accept_ready", 64'(inReady), 64'd1);

    // Clear blocks the result handshake in DONE
    inValid = 1'b1; inData = 64'h7;
    @(negedge clk);
    inValid = 1'b0;
    repeat (NCH) @(negedge clk);
    checkOutput("clr_done_valid", 64'(outValid), 64'd1);
    clear = 1'b1; outReady = 1'b1;
    @(negedge clk);
    clear = 1'b0; outReady = 1'b0;
    checkOutput("clr_done_drop", 64'(outValid), 64'd0);
    checkOutput("clr_done_ready", 64'(inReady), 64'd1);
    checkOutput("clr_done_count", 64'(outCount), 64'd3);
    lastCount = 3;

    // Random jobs against the $countones model
    for (int j = 0; j < 16; j++) begin
      d = {$urandom, $urandom};
      case (j % 4)
        1: d = d & {$urandom, $urandom};
        2: d = d | {$urandom, $urandom};
        3: d = d & 64'hFFFF;
        default: d = d;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(d, int'($urandom_range(0, 3)));
    end

    // Single-chunk instance
    runSmallJob(17'h1FFFF);
    runSmallJob(17'h0);
    for (int j = 0; j < 6; j++) begin
      runSmallJob(17'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
